// File: rtl/adder_tile_sequencer_pkg.sv
// Shared definitions for the adder tile sequencer: FSM state encoding,
// default widths and the order in which operand words arrive on the
// upstream stream.
package adder_tile_sequencer_pkg;

  localparam int WORD_W_DEFAULT  = 32;    // IEEE-754 single
  localparam int TIMEOUT_DEFAULT = 1023;  // cycles allowed in START

  localparam int NUM_OPND = 8;            // A11..A22, B11..B22
  localparam int NUM_RES  = 4;            // C11..C22

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_ACK   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Slot index of each operand word; the upstream stream delivers them in
  // ascending slot order.
  localparam logic [2:0] IDX_A11 = 3'd0;
  localparam logic [2:0] IDX_A12 = 3'd1;
  localparam logic [2:0] IDX_A21 = 3'd2;
  localparam logic [2:0] IDX_A22 = 3'd3;
  localparam logic [2:0] IDX_B11 = 3'd4;
  localparam logic [2:0] IDX_B12 = 3'd5;
  localparam logic [2:0] IDX_B21 = 3'd6;
  localparam logic [2:0] IDX_B22 = 3'd7;

  localparam logic [1:0] RES_LAST = 2'd3;

endpackage

// File: rtl/adder_tile_sequencer_seq_timeout_counter.sv
// Cycle counter used to bound how long the sequencer waits for the adder.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clear    : return the count to zero
//   enable   : count this cycle
//   expire   : high on the LIMIT-th consecutive enabled cycle
module adder_tile_sequencer_seq_timeout_counter #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // The count starts at 0 on the first enabled cycle, so LIMIT-1 marks the
  // LIMIT-th one. The owner leaves the counting state on expire, so the
  // count never runs past this value.
  assign expire = enable && (count_reg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/adder_tile_sequencer.sv
// Sequencer between a word stream and a 2x2 matrix adder (AxA_adder).
// Collects eight operand words (A11,A12,A21,A22,B11,B12,B21,B22), starts the
// adder, captures its four result words, acknowledges it, then streams the
// results C11,C12,C21,C22 downstream. Results pass through bit-exact.
// Ports:
//   input_Clk, input_Reset          : clock, asynchronous active-high reset
//   input_Data/Valid, output_Ready  : upstream operand stream
//   output_A11..A22, output_B11..B22: operands to the adder
//   output_Start, input_Stable      : adder start / result-valid handshake
//   input_C11..C22, output_C_Ack    : adder results and acknowledge
//   output_Data/Valid, input_Ready  : downstream result stream
//   output_Timeout                  : sticky, adder never answered a Start
module adder_tile_sequencer
  import adder_tile_sequencer_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              input_Clk,
  input  logic              input_Reset,
  input  logic [WORD_W-1:0] input_Data,
  input  logic              input_Valid,
  output logic              output_Ready,
  output logic [WORD_W-1:0] output_A11,
  output logic [WORD_W-1:0] output_A12,
  output logic [WORD_W-1:0] output_A21,
  output logic [WORD_W-1:0] output_A22,
  output logic [WORD_W-1:0] output_B11,
  output logic [WORD_W-1:0] output_B12,
  output logic [WORD_W-1:0] output_B21,
  output logic [WORD_W-1:0] output_B22,
  output logic              output_Start,
  input  logic              input_Stable,
  input  logic [WORD_W-1:0] input_C11,
  input  logic [WORD_W-1:0] input_C12,
  input  logic [WORD_W-1:0] input_C21,
  input  logic [WORD_W-1:0] input_C22,
  output logic              output_C_Ack,
  output logic [WORD_W-1:0] output_Data,
  output logic              output_Valid,
  input  logic              input_Ready,
  output logic              output_Timeout
);

  state_t      state_reg, state_next;
  logic [2:0]  word_cnt_reg, word_cnt_next;
  logic [1:0]  drain_cnt_reg, drain_cnt_next;
  logic        timeout_reg, timeout_next;
  logic        load_word;
  logic        capture;
  logic        expire;

  logic [WORD_W-1:0] opnd_reg [0:NUM_OPND-1];
  logic [WORD_W-1:0] res_reg  [0:NUM_RES-1];
  logic [WORD_W-1:0] c_in     [0:NUM_RES-1];

  assign c_in[0] = input_C11;
  assign c_in[1] = input_C12;
  assign c_in[2] = input_C21;
  assign c_in[3] = input_C22;

  // Operand slots are only written by LOAD handshakes, so they stay stable
  // through START/ACK/DRAIN and until the next tile overwrites them.
  for (genvar gi = 0; gi < NUM_OPND; gi++) begin : g_opnd
    always_ff @(posedge input_Clk or posedge input_Reset) begin
      if (input_Reset) begin
        opnd_reg[gi] <= '0;
      end else if (load_word && (word_cnt_reg == 3'(gi))) begin
        opnd_reg[gi] <= input_Data;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RES; gi++) begin : g_res
    always_ff @(posedge input_Clk or posedge input_Reset) begin
      if (input_Reset) begin
        res_reg[gi] <= '0;
      end else if (capture) begin
        res_reg[gi] <= c_in[gi];
      end
    end
  end

  assign output_A11 = opnd_reg[IDX_A11];
  assign output_A12 = opnd_reg[IDX_A12];
  assign output_A21 = opnd_reg[IDX_A21];
  assign output_A22 = opnd_reg[IDX_A22];
  assign output_B11 = opnd_reg[IDX_B11];
  assign output_B12 = opnd_reg[IDX_B12];
  assign output_B21 = opnd_reg[IDX_B21];
  assign output_B22 = opnd_reg[IDX_B22];

  adder_tile_sequencer_seq_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk    (input_Clk),
    .rst    (input_Reset),
    .clear  (state_reg != ST_START),
    .enable (state_reg == ST_START),
    .expire (expire)
  );

  always_ff @(posedge input_Clk or posedge input_Reset) begin
    if (input_Reset) begin
      state_reg     <= ST_LOAD;
      word_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      word_cnt_reg  <= word_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    word_cnt_next  = word_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    timeout_next   = timeout_reg;
    load_word      = 1'b0;
    capture        = 1'b0;
    output_Ready   = 1'b0;
    output_Start   = 1'b0;
    output_C_Ack   = 1'b0;
    output_Valid   = 1'b0;
    output_Data    = '0;

    case (state_reg)
      ST_LOAD: begin
        // The reset state is LOAD, so Ready is masked while reset is held.
        output_Ready = ~input_Reset;
        if (input_Valid) begin
          load_word     = 1'b1;
          word_cnt_next = word_cnt_reg + 3'd1;
          if (word_cnt_reg == IDX_B22) begin
            state_next = ST_START;
          end
        end
      end
      ST_START: begin
        output_Start = 1'b1;
        // A response wins over an expiry landing on the same cycle; Stable
        // already high on entry counts as a response.
        if (input_Stable) begin
          capture    = 1'b1;
          state_next = ST_ACK;
        end else if (expire) begin
          timeout_next  = 1'b1;
          word_cnt_next = '0;
          state_next    = ST_LOAD;
        end
      end
      ST_ACK: begin
        output_C_Ack = 1'b1;
        if (!input_Stable) begin
          drain_cnt_next = '0;
          state_next     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        output_Valid = 1'b1;
        output_Data  = res_reg[drain_cnt_reg];
        if (input_Ready) begin
          drain_cnt_next = drain_cnt_reg + 2'd1;
          if (drain_cnt_reg == RES_LAST) begin
            word_cnt_next = '0;
            state_next    = ST_LOAD;
          end
        end
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  assign output_Timeout = timeout_reg;

endmodule
